fakeram_banked_1rw: RTL and testbench

//  Parametrised, banked single-port RAM with valid/ready request and response channels.

---
 rtl/fakeram_pkg.sv | 15 +
 rtl/fakeram_bank_1rw.sv | 28 ++
 rtl/fakeram_banked_1rw.sv | 113 +++++++++++
 tb/tb_fakeram_banked_1rw.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fakeram_pkg.sv
// Shared helpers for the banked fakeram: credit-counter sizing and bank selection.
package fakeram_pkg;

   function automatic int credit_w(input int els);
      return $clog2(els + 1);
   endfunction

   // Bank index is the address bits above the per-bank word offset.
   function automatic int unsigned bank_of(input int unsigned addr,
                                           input int unsigned bank_words,
                                           input int unsigned banks);
      return (addr >> $clog2(bank_words)) & (banks - 1);
   endfunction

endpackage

// File: rtl/fakeram_bank_1rw.sv
// Behavioural single-port bank with a registered 1-cycle read and per-bit write mask.
module fakeram_bank_1rw #(
   parameter  int BITS  = 64,
   parameter  int WORDS = 512,
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic            clk,
   input  logic            ce,
   input  logic            we,
   input  logic [AW-1:0]   addr,
   input  logic [BITS-1:0] wd,
   input  logic [BITS-1:0] wmsk,
   output logic [BITS-1:0] rd
);

   logic [BITS-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (ce) begin
         if (we) begin
            mem[addr] <= (mem[addr] & ~wmsk) | (wd & wmsk);
         end else begin
            rd <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/fakeram_banked_1rw.sv
// Banked 1RW RAM with valid/ready request port and a credit-protected read response FIFO.
module fakeram_banked_1rw
   import fakeram_pkg::*;
#(
   parameter  int BITS       = 64,
   parameter  int BANK_WORDS = 512,
   parameter  int BANKS      = 2,
   parameter  int RESP_ELS   = 3,
   localparam int ADDR_W     = $clog2(BANKS * BANK_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_vi,
   output logic              req_readyo,
   input  logic              req_wei,
   input  logic [ADDR_W-1:0] req_addri,
   input  logic [BITS-1:0]   req_wdi,
   input  logic [BITS-1:0]   req_wmski,
   output logic              resp_vo,
   input  logic              resp_readyi,
   output logic [BITS-1:0]   resp_rdo
);

   localparam int WORD_W = $clog2(BANK_WORDS);
   localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int CNT_W  = credit_w(RESP_ELS);
   localparam int PTR_W  = (RESP_ELS > 1) ? $clog2(RESP_ELS) : 1;

   logic              accept;
   logic              rd_acc;
   logic [BANK_W-1:0] bank_sel;
   logic [BITS-1:0]   bank_rd [BANKS];

   logic              rd_v_q;
   logic [BANK_W-1:0] rd_bank_q;

   logic [BITS-1:0]   fifo_mem [RESP_ELS];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  occ;
   logic [CNT_W-1:0]  used;
   logic              push;
   logic              pop;

   // used = reads in the bank pipeline + entries in the FIFO, so a full
   // FIFO can never receive a push it has no room for.
   assign req_readyo = ~reset & (used < CNT_W'(RESP_ELS));
   assign accept     = req_vi & req_readyo;
   assign rd_acc     = accept & ~req_wei;
   assign bank_sel   = BANK_W'(bank_of(32'(req_addri), BANK_WORDS, BANKS));

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      fakeram_bank_1rw #(
         .BITS  (BITS),
         .WORDS (BANK_WORDS)
      ) u_bank (
         .clk  (clk),
         .ce   (accept & (bank_sel == BANK_W'(b))),
         .we   (req_wei),
         .addr (req_addri[WORD_W-1:0]),
         .wd   (req_wdi),
         .wmsk (req_wmski),
         .rd   (bank_rd[b])
      );
   end

   assign push     = rd_v_q;
   assign resp_vo  = (occ != '0);
   assign pop      = resp_vo & resp_readyi;
   assign resp_rdo = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_v_q <= 1'b0;
         used   <= '0;
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         rd_v_q <= rd_acc;
         if (rd_acc && !pop) begin
            used <= used + CNT_W'(1);
         end else if (!rd_acc && pop) begin
            used <= used - CNT_W'(1);
         end
         if (push && !pop) begin
            occ <= occ + CNT_W'(1);
         end else if (!push && pop) begin
            occ <= occ - CNT_W'(1);
         end
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_W'(RESP_ELS - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(RESP_ELS - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      rd_bank_q <= bank_sel;
      if (push) begin
         fifo_mem[wr_ptr] <= bank_rd[rd_bank_q];
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && occ == CNT_W'(RESP_ELS)));

   a_req_known : assert property (@(posedge clk) disable iff (reset)
      req_vi |-> !$isunknown({req_wei, req_addri}));

endmodule

// File: tb/tb_fakeram_banked_1rw.sv
// Self-checking bench: directed scenarios plus randomized traffic against a word-array model.
module tb_fakeram_banked_1rw;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_vi;
   logic        req_readyo;
   logic        req_wei;
   logic [9:0]  req_addri;
   logic [63:0] req_wdi;
   logic [63:0] req_wmski;
   logic        resp_vo;
   logic        resp_readyi;
   logic [63:0] resp_rdo;

   int checks   = 0;
   int failures = 0;

   logic [63:0] model [1024];
   logic [63:0] exp_q [$];
   logic        hold = 1'b0;
   logic [63:0] hold_data;

   always #5 clk = ~clk;

   fakeram_banked_1rw dut (
      .clk         (clk),
      .reset       (reset),
      .req_vi      (req_vi),
      .req_readyo  (req_readyo),
      .req_wei     (req_wei),
      .req_addri   (req_addri),
      .req_wdi     (req_wdi),
      .req_wmski   (req_wmski),
      .resp_vo     (resp_vo),
      .resp_readyi (resp_readyi),
      .resp_rdo    (resp_rdo)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Present one request and hold it until it is taken; returns at posedge+1 after accept.
   task automatic issue(input logic we, input logic [9:0] addr,
                        input logic [63:0] wd, input logic [63:0] wmsk);
      int n = 0;
      req_vi    = 1'b1;
      req_wei   = we;
      req_addri = addr;
      req_wdi   = wd;
      req_wmski = wmsk;
      @(negedge clk);
      while (!req_readyo && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("accept_timeout", 64'(req_readyo), 64'd1);
      next();
      req_vi = 1'b0;
   endtask

   // Read with an empty FIFO and resp_readyi=1: data must appear exactly two cycles after accept.
   task automatic read_check(input string tag, input logic [9:0] addr, input logic [63:0] expv);
      issue(1'b0, addr, '0, '0);
      @(negedge clk);
      check({tag, "_vo_n1"}, 64'(resp_vo), 64'd0);
      next();
      @(negedge clk);
      check({tag, "_vo_n2"}, 64'(resp_vo), 64'd1);
      check({tag, "_rdo"}, resp_rdo, expv);
      next();
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         next();
         n++;
      end
      if (n >= 40) check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard: apply accepted writes to the model, queue expected read data, match pops in order.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("hold_vo", 64'(resp_vo), 64'd1);
            check("hold_rdo", resp_rdo, hold_data);
         end
         if (resp_vo && resp_readyi) begin
            if (exp_q.size() == 0) check("resp_unexpected", 64'(resp_vo), 64'd0);
            else check("resp_data", resp_rdo, exp_q.pop_front());
         end
         if (req_vi && req_readyo) begin
            if (req_wei) begin
               for (int i = 0; i < 64; i++)
                  if (req_wmski[i]) model[req_addri][i] = req_wdi[i];
            end else begin
               exp_q.push_back(model[req_addri]);
            end
         end
         hold      = resp_vo && !resp_readyi;
         hold_data = resp_rdo;
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int accepted;
      logic [63:0] a_data;
      logic [63:0] b_data;

      reset       = 1'b1;
      req_vi      = 1'b0;
      req_wei     = 1'b0;
      req_addri   = '0;
      req_wdi     = '0;
      req_wmski   = '0;
      resp_readyi = 1'b1;

      // Reset: three reset edges, outputs quiet throughout.
      next();
      repeat (2) begin
         @(negedge clk);
         check("rst_vo", 64'(resp_vo), 64'd0);
         check("rst_ready", 64'(req_readyo), 64'd0);
         next();
      end
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(req_readyo), 64'd1);
      next();

      // Full write then read-back, then a partial-mask overwrite.
      issue(1'b1, 10'd5, 64'hDEAD_BEEF_0123_4567, '1);
      read_check("rd_full", 10'd5, 64'hDEAD_BEEF_0123_4567);
      issue(1'b1, 10'd5, '1, 64'h0000_0000_FFFF_0000);
      read_check("rd_mask", 10'd5, 64'hDEAD_BEEF_FFFF_4567);

      // Bank isolation: same word offset in bank 0 and bank 1.
      a_data = 64'h1111_2222_3333_4444;
      b_data = 64'hAAAA_BBBB_CCCC_DDDD;
      issue(1'b1, 10'd5, a_data, '1);
      issue(1'b1, 10'd517, b_data, '1);
      read_check("rd_bank0", 10'd5, a_data);
      read_check("rd_bank1", 10'd517, b_data);

      // Back-pressure: five back-to-back read attempts with the consumer stalled.
      resp_readyi = 1'b0;
      accepted    = 0;
      req_vi      = 1'b1;
      req_wei     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req_addri = (i % 2 == 1) ? 10'd517 : 10'd5;
         @(negedge clk);
         if (req_ready_o_sample()) accepted++;
         next();
      end
      req_vi = 1'b0;
      check("bp_accepted", 64'(accepted), 64'd3);
      @(negedge clk);
      check("bp_ready_low", 64'(req_readyo), 64'd0);
      check("bp_vo_held", 64'(resp_vo), 64'd1);
      next();
      resp_readyi = 1'b1;
      drain("bp_drain");
      @(negedge clk);
      check("bp_ready_recover", 64'(req_readyo), 64'd1);
      next();

      // Fill every word with known data so random reads compare against defined values.
      for (int a = 0; a < 1024; a++) issue(1'b1, 10'(a), {$urandom, $urandom}, '1);

      // Random mixed traffic with random masks and random consumer stalls.
      for (int i = 0; i < 400; i++) begin
         req_vi      = ($urandom_range(3) != 0);
         req_wei     = $urandom_range(1) == 1;
         req_addri   = 10'($urandom_range(1023));
         req_wdi     = {$urandom, $urandom};
         req_wmski   = {$urandom, $urandom};
         resp_readyi = ($urandom_range(3) != 0);
         next();
      end
      req_vi      = 1'b0;
      resp_readyi = 1'b1;
      drain("rand_drain");

      // Streaming: one read accepted every cycle with no bubbles.
      req_vi  = 1'b1;
      req_wei = 1'b0;
      for (int i = 0; i < 100; i++) begin
         req_addri = 10'($urandom_range(1023));
         @(negedge clk);
         check("stream_ready", 64'(req_readyo), 64'd1);
         next();
      end
      req_vi = 1'b0;
      drain("stream_drain");

      // Reset one cycle after two reads are accepted: everything in flight is discarded.
      resp_readyi = 1'b0;
      issue(1'b0, 10'd5, '0, '0);
      issue(1'b0, 10'd517, '0, '0);
      reset = 1'b1;
      next();
      @(negedge clk);
      check("midrst_vo", 64'(resp_vo), 64'd0);
      check("midrst_ready", 64'(req_readyo), 64'd0);
      next();
      reset       = 1'b0;
      resp_readyi = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("postrst_vo", 64'(resp_vo), 64'd0);
         next();
      end
      read_check("rst_keep0", 10'd5, model[5]);
      read_check("rst_keep1", 10'd517, model[517]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic logic req_ready_o_sample();
      return req_readyo;
   endfunction

endmodule
